pc_sequencer: RTL and testbench

Front-end control block that decides every cycle whether and where the ProgramCounter register moves. It arbitrates between sequential fetch, branch/jump redirects, return-from-interrupt and interrupt entry. It also honours hazard stalls, generates pipeline flush, and holds the exception return address (EPC) and the global interrupt-enable bit. It sits between the hazard/branch units and the ProgramCounter, driving its PCNext and PCWrite.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_flush_counter.sv | 35 +++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: state encoding,
// address type and the default increment/vector values.
package pc_seq_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_e;

  localparam addr_t PC_INC     = 16'd2;
  localparam addr_t IRQ_VECTOR = 16'h0004;
  localparam int    CNT_W      = 3;

endpackage

// File: rtl/pc_flush_counter.sv
// Down-counter that times the FLUSH window: loads on redirect, decrements
// only on unstalled cycles, and flags zero for the exit decision.
module pc_flush_counter
  import pc_seq_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Per-cycle PC steering: sequential fetch, branch/jump/reti redirects and
// interrupt entry, with a timed flush window, EPC and interrupt enable.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter addr_t PC_INC_P     = PC_INC,
  parameter addr_t IRQ_VECTOR_P = IRQ_VECTOR,
  parameter int    FLUSH_CYCLES = 2
) (
  input  logic      Clk,
  input  logic      Reset,
  input  addr_t     PCResult,
  input  logic      Stall,
  input  logic      BranchTaken,
  input  addr_t     BranchTarget,
  input  logic      Jump,
  input  addr_t     JumpTarget,
  input  logic      Reti,
  input  logic      IrqReq,
  input  logic      IeSet,
  input  logic      IeClr,
  output addr_t     PCNext,
  output logic      PCWrite,
  output logic      Flush,
  output logic      IrqAck,
  output addr_t     EPC,
  output logic      IntEnable,
  output pc_state_e state_dbg
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  pc_state_e state_q, state_d;
  addr_t     epc_q, epc_d;
  logic      ie_q, ie_d;
  logic      cnt_zero;

  // Redirect/interrupt decode is only live in RUN; in FLUSH these inputs
  // belong to squashed instructions.
  logic in_run, take_reti, take_br, take_jmp, take_irq, enter_flush;
  always_comb begin
    in_run      = (state_q == RUN);
    take_reti   = in_run && Reti;
    take_br     = in_run && !Reti && BranchTaken;
    take_jmp    = in_run && !Reti && !BranchTaken && Jump;
    take_irq    = in_run && !Reti && !BranchTaken && !Jump && !Stall && IrqReq && ie_q;
    enter_flush = take_reti || take_br || take_jmp || take_irq;
  end

  pc_flush_counter u_flush_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (enter_flush),
    .load_val (FLUSH_LOAD),
    .dec      ((state_q == FLUSH) && !Stall),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      epc_q   <= '0;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    ie_d    = ie_q;
    case (state_q)
      RUN:     if (enter_flush) state_d = FLUSH;
      FLUSH:   if (cnt_zero && !Stall) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (take_irq) epc_d = PCResult;
    // IeClr beats IeSet; reti/interrupt entry beat both.
    if (IeSet) ie_d = 1'b1;
    if (IeClr) ie_d = 1'b0;
    if (take_reti) ie_d = 1'b1;
    if (take_irq) ie_d = 1'b0;
  end

  always_comb begin
    PCNext  = PCResult + PC_INC_P;
    PCWrite = 1'b1;
    Flush   = (state_q == FLUSH);
    IrqAck  = 1'b0;
    if (Stall) begin
      PCNext  = PCResult;
      PCWrite = 1'b0;
    end
    if (take_reti) begin
      PCNext  = epc_q;
      PCWrite = 1'b1;
      Flush   = 1'b1;
    end else if (take_br) begin
      PCNext  = BranchTarget;
      PCWrite = 1'b1;
      Flush   = 1'b1;
    end else if (take_jmp) begin
      PCNext  = JumpTarget;
      PCWrite = 1'b1;
      Flush   = 1'b1;
    end else if (take_irq) begin
      PCNext  = IRQ_VECTOR_P;
      PCWrite = 1'b1;
      Flush   = 1'b1;
      IrqAck  = 1'b1;
    end
    if (Reset) begin
      PCNext  = '0;
      PCWrite = 1'b0;
      Flush   = 1'b0;
      IrqAck  = 1'b0;
    end
  end

  assign EPC       = epc_q;
  assign IntEnable = ie_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a small PC register closes the loop,
// expected values are hand-computed constants.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic      Clk = 1'b0;
  logic      Reset;
  addr_t     pc;
  logic      Stall, BranchTaken, Jump, Reti, IrqReq, IeSet, IeClr;
  addr_t     BranchTarget, JumpTarget;
  addr_t     PCNext, EPC;
  logic      PCWrite, Flush, IrqAck, IntEnable;
  pc_state_e state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCResult     (pc),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Reti         (Reti),
    .IrqReq       (IrqReq),
    .IeSet        (IeSet),
    .IeClr        (IeClr),
    .PCNext       (PCNext),
    .PCWrite      (PCWrite),
    .Flush        (Flush),
    .IrqAck       (IrqAck),
    .EPC          (EPC),
    .IntEnable    (IntEnable),
    .state_dbg    (state_dbg)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Stall = 0; BranchTaken = 0; Jump = 0; Reti = 0; IrqReq = 0;
    IeSet = 0; IeClr = 0; BranchTarget = '0; JumpTarget = '0;
  endtask

  // Advance one clock; the bench-side PC register follows PCWrite/PCNext.
  task automatic cyc();
    logic  wr, rst;
    addr_t nx;
    wr = PCWrite; nx = PCNext; rst = Reset;
    @(posedge Clk);
    #1;
    if (rst) pc = '0;
    else if (wr) pc = nx;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clear_inputs();
    pc = '0;
    Reset = 1;
    @(posedge Clk); #1;
    BranchTaken = 1; BranchTarget = 16'h0040;
    settle();
    check("rst_pcwrite", PCWrite, 0);
    check("rst_flush", Flush, 0);
    check("rst_irqack", IrqAck, 0);
    check("rst_pcnext", PCNext, 16'h0000);
    cyc();
    clear_inputs();
    settle();
    check("rst_epc", EPC, 16'h0000);
    check("rst_ie", IntEnable, 0);
    check("rst_state", state_dbg, RUN);
    Reset = 0;

    // Sequential fetch
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0006); exp_q.push_back(16'h0008);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("seq_pcnext", PCNext, exp_q.pop_front());
      check("seq_pcwrite", PCWrite, 1);
      check("seq_flush", Flush, 0);
      cyc();
    end

    // Branch overriding a stall, then a jump ignored during FLUSH
    pc = 16'h0010;
    BranchTaken = 1; BranchTarget = 16'h0040; Stall = 1;
    settle();
    check("br_pcnext", PCNext, 16'h0040);
    check("br_pcwrite", PCWrite, 1);
    check("br_flush", Flush, 1);
    cyc(); clear_inputs();
    Jump = 1; JumpTarget = 16'h0100;
    settle();
    check("fl1_state", state_dbg, FLUSH);
    check("fl1_flush", Flush, 1);
    check("fl1_jump_ignored", PCNext, 16'h0042);
    cyc(); clear_inputs();
    settle();
    check("fl2_flush", Flush, 1);
    check("fl2_pcnext", PCNext, 16'h0044);
    cyc();
    settle();
    check("br_end_flush", Flush, 0);
    check("br_end_state", state_dbg, RUN);
    check("br_end_pcnext", PCNext, 16'h0046);

    // Enable interrupts, take one at PC=0020
    IeSet = 1;
    settle();
    check("ieset_not_yet", IntEnable, 0);
    cyc(); clear_inputs();
    pc = 16'h0020; IrqReq = 1;
    settle();
    check("irq_ie_before", IntEnable, 1);
    check("irq_ack", IrqAck, 1);
    check("irq_pcnext", PCNext, 16'h0004);
    check("irq_flush", Flush, 1);
    cyc();
    settle();
    check("irq_ack_once", IrqAck, 0);
    check("irq_epc", EPC, 16'h0020);
    check("irq_ie_cleared", IntEnable, 0);
    check("irq_fl_pcnext", PCNext, 16'h0006);
    cyc();
    settle();
    check("irq_fl2_ack", IrqAck, 0);
    cyc();
    settle();
    check("irq_masked_ack", IrqAck, 0);
    check("irq_masked_pcnext", PCNext, 16'h000A);
    cyc();

    // Reti with IrqReq still pending: Reti wins
    Reti = 1;
    settle();
    check("reti_pcnext", PCNext, 16'h0020);
    check("reti_flush", Flush, 1);
    check("reti_no_ack", IrqAck, 0);
    cyc(); Reti = 0;
    settle();
    check("reti_ie_set", IntEnable, 1);
    check("reti_fl1_ack", IrqAck, 0);
    check("reti_fl1_flush", Flush, 1);
    check("reti_fl1_pcnext", PCNext, 16'h0022);
    cyc();
    settle();
    check("reti_fl2_flush", Flush, 1);
    check("reti_fl2_ack", IrqAck, 0);
    cyc();

    // Stall holds off the pending interrupt for 3 cycles
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_pcwrite", PCWrite, 0);
      check("stall_no_ack", IrqAck, 0);
      check("stall_pcnext", PCNext, 16'h0024);
      cyc();
    end
    Stall = 0;
    settle();
    check("unstall_ack", IrqAck, 1);
    check("unstall_pcnext", PCNext, 16'h0004);
    cyc(); IrqReq = 0;
    settle();
    check("unstall_epc", EPC, 16'h0024);

    // Stall inside FLUSH freezes the flush counter
    Stall = 1;
    settle();
    check("flstall_flush", Flush, 1);
    check("flstall_pcwrite", PCWrite, 0);
    cyc(); Stall = 0;
    settle();
    check("flstall_hold", Flush, 1);
    check("flstall_pcnext", PCNext, 16'h0006);
    cyc();
    settle();
    check("flstall_last", Flush, 1);
    cyc();
    settle();
    check("flstall_exit", Flush, 0);

    // IeSet alone, then IeSet+IeClr together
    IeSet = 1;
    cyc();
    settle();
    check("ie_set", IntEnable, 1);
    IeClr = 1;
    cyc(); clear_inputs();
    settle();
    check("ie_clr_wins", IntEnable, 0);

    // Wrap at FFFE, then reset in the middle of a FLUSH window
    pc = 16'hFFFE;
    settle();
    check("wrap_pcnext", PCNext, 16'h0000);
    Jump = 1; JumpTarget = 16'h0100;
    settle();
    check("jmp_pcnext", PCNext, 16'h0100);
    cyc(); clear_inputs();
    Reset = 1;
    settle();
    check("rstfl_flush", Flush, 0);
    check("rstfl_pcwrite", PCWrite, 0);
    cyc(); Reset = 0;
    settle();
    check("rstfl_state", state_dbg, RUN);
    check("rstfl_flush_after", Flush, 0);
    check("rstfl_epc", EPC, 16'h0000);
    check("rstfl_pcnext", PCNext, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
